pwm_compare_deadtime: RTL and testbench

Downstream stage of the single-carrier generator. Compares the 16-bit carrier against a shadow-registered compare value and produces one complementary high/low gate-drive pair with programmable dead time. Compare value and dead time are loaded into shadow registers on the generator's maskevent pulse, so updates take effect glitch-free at carrier mask points.

---
 rtl/pwm_compare_deadtime_if.sv | 35 +++
 rtl/pwm_compare_deadtime.sv | 132 +++++++++++++
 tb/tb_pwm_compare_deadtime.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_compare_deadtime_if.sv
// Signal bundle between the carrier generator side and the compare/dead-time
// stage.
//
// Handshake: there is no valid/ready pair. The stage samples every input on
// each rising clk. maskevent is a single-cycle strobe that opens the shadow
// registers for that edge. All outputs are registered and change only on
// rising clk or on the asynchronous reset.
interface pwm_compare_deadtime_if #(
    parameter int CNT_WIDTH = 16,
    parameter int DT_WIDTH  = 10
);
    logic                 pwm_onoff;
    logic [CNT_WIDTH-1:0] carrier;
    logic                 maskevent;
    logic [CNT_WIDTH-1:0] compare;
    logic [DT_WIDTH-1:0]  deadtime;
    logic                 out_polarity;
    logic                 pwm_h;
    logic                 pwm_l;
    logic                 ref_out;
    logic                 dt_busy;
    logic [2:0]           state_dbg;

    // Driving side: the carrier generator, or a testbench.
    modport master (
        output pwm_onoff, carrier, maskevent, compare, deadtime, out_polarity,
        input  pwm_h, pwm_l, ref_out, dt_busy, state_dbg
    );

    // Compare/dead-time stage.
    modport slave (
        input  pwm_onoff, carrier, maskevent, compare, deadtime, out_polarity,
        output pwm_h, pwm_l, ref_out, dt_busy, state_dbg
    );
endinterface

// File: rtl/pwm_compare_deadtime.sv
// Carrier comparator with shadowed compare and dead time. Drives one
// complementary high/low gate pair with programmable dead time.
// state_dbg shows the FSM state: 0 IDLE, 1 LOW, 2 DT_RISE, 3 HIGH, 4 DT_FALL.
module pwm_compare_deadtime #(
    parameter int CNT_WIDTH = 16,
    parameter int DT_WIDTH  = 10
) (
    input logic                  clk,
    input logic                  reset,
    pwm_compare_deadtime_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOW     = 3'd1,
        DT_RISE = 3'd2,
        HIGH    = 3'd3,
        DT_FALL = 3'd4
    } state_t;

    logic [CNT_WIDTH-1:0] cmp_sh;
    logic [DT_WIDTH-1:0]  dt_sh;
    logic                 ref_q;
    logic [DT_WIDTH-1:0]  dt_cnt;
    logic [DT_WIDTH-1:0]  dt_cnt_nxt;
    state_t               state;
    state_t               state_nxt;
    logic                 pwm_h_q;
    logic                 pwm_l_q;
    logic                 dt_busy_q;

    // Shadow registers open on the mask strobe, and stay open while stopped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_sh <= '0;
            dt_sh  <= '0;
        end else if (bus.maskevent || !bus.pwm_onoff) begin
            cmp_sh <= bus.compare;
            dt_sh  <= bus.deadtime;
        end
    end

    // Registered comparator: the reference is high while carrier < compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_q <= 1'b0;
        end else begin
            ref_q <= (bus.carrier < cmp_sh);
        end
    end

    // Next-state and dead-time counter logic. pwm_onoff has top priority.
    always_comb begin
        state_nxt  = state;
        dt_cnt_nxt = dt_cnt;
        if (!bus.pwm_onoff) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = LOW;
                end
                LOW: begin
                    if (ref_q) begin
                        if (dt_sh == '0) begin
                            state_nxt = HIGH;
                        end else begin
                            state_nxt  = DT_RISE;
                            dt_cnt_nxt = dt_sh - DT_WIDTH'(1);
                        end
                    end
                end
                DT_RISE: begin
                    if (!ref_q) begin
                        state_nxt = LOW;
                    end else if (dt_cnt == '0) begin
                        state_nxt = HIGH;
                    end else begin
                        dt_cnt_nxt = dt_cnt - DT_WIDTH'(1);
                    end
                end
                HIGH: begin
                    if (!ref_q) begin
                        if (dt_sh == '0) begin
                            state_nxt = LOW;
                        end else begin
                            state_nxt  = DT_FALL;
                            dt_cnt_nxt = dt_sh - DT_WIDTH'(1);
                        end
                    end
                end
                DT_FALL: begin
                    if (ref_q) begin
                        state_nxt = HIGH;
                    end else if (dt_cnt == '0) begin
                        state_nxt = LOW;
                    end else begin
                        dt_cnt_nxt = dt_cnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // FSM register. Outputs are decoded from the next state, so they line up
    // with the state they describe. Polarity is applied at the register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dt_cnt    <= '0;
            pwm_h_q   <= 1'b0;
            pwm_l_q   <= 1'b0;
            dt_busy_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            dt_cnt    <= dt_cnt_nxt;
            pwm_h_q   <= (state_nxt == HIGH) ^ bus.out_polarity;
            pwm_l_q   <= (state_nxt == LOW)  ^ bus.out_polarity;
            dt_busy_q <= (state_nxt == DT_RISE) || (state_nxt == DT_FALL);
        end
    end

    assign bus.pwm_h     = pwm_h_q;
    assign bus.pwm_l     = pwm_l_q;
    assign bus.ref_out   = ref_q;
    assign bus.dt_busy   = dt_busy_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Bench for pwm_compare_deadtime. A sawtooth carrier runs 0..99, with a
// mask strobe at carrier 0.
module tb_pwm_compare_deadtime;

    localparam int PERIOD = 100;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pwm_compare_deadtime_if #(.CNT_WIDTH(16), .DT_WIDTH(10)) bus ();

    pwm_compare_deadtime #(.CNT_WIDTH(16), .DT_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int          checks;
    int          errors;
    logic [0:0]  exp_q[$];
    logic [15:0] cmp_m;
    logic        pol_m;
    logic [15:0] c_val;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One clock. Drive the carrier and push the expected reference. After the
    // edge, pop and compare it, and check the two outputs are never both active.
    task automatic step();
        logic [0:0] e;
        logic [0:0] got;
        logic       h_act;
        logic       l_act;
        bus.carrier   = c_val;
        bus.maskevent = (c_val == 16'd0);
        e[0] = (c_val < cmp_m);
        exp_q.push_back(e);
        if (bus.maskevent || !bus.pwm_onoff) cmp_m = bus.compare;
        pol_m = bus.out_polarity;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("ref_out", int'(bus.ref_out), int'(got));
        h_act = bus.pwm_h ^ pol_m;
        l_act = bus.pwm_l ^ pol_m;
        chk("exclusive", int'(h_act & l_act), 0);
        c_val = (c_val == 16'(PERIOD - 1)) ? 16'd0 : c_val + 16'd1;
    endtask

    // Run one full carrier period from carrier 0. Count cycles with the high
    // side active, the low side active and dt_busy set. If check_runs is set,
    // check the length of each dead interval that starts inside the period.
    // chg_at >= 0 changes compare at that carrier value, with no mask strobe.
    task automatic run_period(output int nh, output int nl, output int nb,
                              input bit check_runs, input int exp_run,
                              input int chg_at, input logic [15:0] chg_cmp);
        bit in_run;
        bit run_valid;
        int run_len;
        logic h_act;
        logic l_act;
        while (c_val != 16'd0) step();
        nh = 0; nl = 0; nb = 0;
        in_run = 1'b1; run_valid = 1'b0; run_len = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == chg_at) bus.compare = chg_cmp;
            step();
            h_act = bus.pwm_h ^ pol_m;
            l_act = bus.pwm_l ^ pol_m;
            if (h_act) nh++;
            if (l_act) nl++;
            if (bus.dt_busy) nb++;
            if (!h_act && !l_act) begin
                if (!in_run) begin
                    in_run = 1'b1; run_valid = 1'b1; run_len = 0;
                end
                run_len++;
            end else begin
                if (in_run && run_valid && check_runs) chk("dead_run_len", run_len, exp_run);
                in_run = 1'b0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   cmp;
        int   dt;
        logic pol;
        int   exp_h;
        int   exp_l;
        int   exp_b;
        int   exp_run;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nh, nl, nb;
        int waited;

        checks = 0; errors = 0;
        cmp_m = 16'd0; pol_m = 1'b0; c_val = 16'd0;

        // Shadow load does not apply when compare changes mid-period.
        // Each row lists: compare, dead time, polarity, expected cycles per
        // period with the high side active, with the low side active, with
        // dt_busy set, and the expected dead-interval length.
        vecs[0] = '{40, 5, 1'b0, 35, 55, 10, 5};
        vecs[1] = '{40, 5, 1'b1, 35, 55, 10, 5};
        vecs[2] = '{40, 0, 1'b0, 40, 60, 0, 0};
        vecs[3] = '{3, 10, 1'b0, 0, 97, 3, 3};
        vecs[4] = '{70, 5, 1'b0, 65, 25, 10, 5};
        vecs[5] = '{0, 5, 1'b0, 0, 100, 0, 0};
        vecs[6] = '{100, 5, 1'b0, 100, 0, 0, 0};
        vecs[7] = '{1, 0, 1'b0, 1, 99, 0, 0};

        // ---- reset ----
        reset = 1'b0;
        bus.pwm_onoff = 1'b0; bus.carrier = '0; bus.maskevent = 1'b0;
        bus.compare = '0; bus.deadtime = '0; bus.out_polarity = 1'b1;
        #2;
        chk("rst_pwm_h", int'(bus.pwm_h), 0);
        chk("rst_pwm_l", int'(bus.pwm_l), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_pwm_h", int'(bus.pwm_h), 0);
        chk("rst_hold_ref", int'(bus.ref_out), 0);
        chk("rst_hold_busy", int'(bus.dt_busy), 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("pol1_idle_h", int'(bus.pwm_h), 1);
        chk("pol1_idle_l", int'(bus.pwm_l), 1);
        chk("pol1_idle_busy", int'(bus.dt_busy), 0);
        bus.out_polarity = 1'b0;
        step();
        chk("pol0_idle_h", int'(bus.pwm_h), 0);
        chk("pol0_idle_l", int'(bus.pwm_l), 0);
        chk("idle_state", int'(bus.state_dbg), 0);

        // ---- table-driven periods ----
        bus.pwm_onoff = 1'b1;
        for (int v = 0; v < 8; v++) begin
            bus.compare      = vecs[v].cmp[15:0];
            bus.deadtime     = vecs[v].dt[9:0];
            bus.out_polarity = vecs[v].pol;
            run_period(nh, nl, nb, 1'b0, 0, -1, 16'd0);
            run_period(nh, nl, nb, 1'b1, vecs[v].exp_run, -1, 16'd0);
            chk($sformatf("v%0d_high_cycles", v), nh, vecs[v].exp_h);
            chk($sformatf("v%0d_low_cycles", v), nl, vecs[v].exp_l);
            chk($sformatf("v%0d_busy_cycles", v), nb, vecs[v].exp_b);
        end

        // ---- zero dead time: both sides switch on the same edge ----
        bus.compare = 16'd40; bus.deadtime = 10'd0; bus.out_polarity = 1'b0;
        run_period(nh, nl, nb, 1'b0, 0, -1, 16'd0);
        while (c_val != 16'd40) step();
        step();
        chk("dt0_fall_before_h", int'(bus.pwm_h), 1);
        chk("dt0_fall_before_l", int'(bus.pwm_l), 0);
        step();
        chk("dt0_fall_h", int'(bus.pwm_h), 0);
        chk("dt0_fall_l", int'(bus.pwm_l), 1);
        chk("dt0_fall_busy", int'(bus.dt_busy), 0);
        while (c_val != 16'd0) step();
        step();
        chk("dt0_rise_before_h", int'(bus.pwm_h), 0);
        chk("dt0_rise_before_l", int'(bus.pwm_l), 1);
        step();
        chk("dt0_rise_h", int'(bus.pwm_h), 1);
        chk("dt0_rise_l", int'(bus.pwm_l), 0);

        // ---- compare changed mid-period: takes effect at next strobe ----
        bus.compare = 16'd40; bus.deadtime = 10'd5;
        run_period(nh, nl, nb, 1'b0, 0, -1, 16'd0);
        run_period(nh, nl, nb, 1'b1, 5, 50, 16'd70);
        chk("shadow_hold_high", nh, 35);
        run_period(nh, nl, nb, 1'b1, 5, -1, 16'd0);
        chk("shadow_new_high", nh, 65);
        chk("shadow_new_busy", nb, 10);

        // ---- pwm_onoff dropped during DT_RISE ----
        bus.compare = 16'd40;
        run_period(nh, nl, nb, 1'b0, 0, -1, 16'd0);
        waited = 0;
        while (bus.state_dbg != 3'd2 && waited < 300) begin
            step();
            waited++;
        end
        chk("wait_dt_rise_timeout", int'(waited >= 300), 0);
        bus.pwm_onoff = 1'b0;
        step();
        chk("off_state", int'(bus.state_dbg), 0);
        chk("off_h", int'(bus.pwm_h), 0);
        chk("off_l", int'(bus.pwm_l), 0);
        chk("off_busy", int'(bus.dt_busy), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("off_hold_h", int'(bus.pwm_h), 0);
        end
        bus.pwm_onoff = 1'b1;
        step();
        chk("on_low_l", int'(bus.pwm_l), 1);
        chk("on_low_h", int'(bus.pwm_h), 0);

        // ---- asynchronous reset mid-HIGH ----
        waited = 0;
        while (bus.pwm_h != 1'b1 && waited < 300) begin
            step();
            waited++;
        end
        chk("wait_high_timeout", int'(waited >= 300), 0);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_h", int'(bus.pwm_h), 0);
        chk("areset_l", int'(bus.pwm_l), 0);
        chk("areset_ref", int'(bus.ref_out), 0);
        chk("areset_busy", int'(bus.dt_busy), 0);
        chk("areset_state", int'(bus.state_dbg), 0);
        @(posedge clk);
        #1;
        chk("areset_hold_h", int'(bus.pwm_h), 0);
        @(negedge clk);
        reset = 1'b1;
        cmp_m = 16'd0;
        exp_q.delete();
        step();
        chk("post_reset_low", int'(bus.pwm_l), 1);

        // ---- report ----
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
